// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared constants, FSM state type and funct3 helpers for the
// RV32I load/store unit.
package rv_lsu_pkg;

    // Byte lanes in one memory word
    localparam int LANES = 4;

    // RV32I load/store size/sign codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_DATA = 2'd1,
        RESP    = 2'd2
    } lsu_state_t;

    // Legal size code for the access direction; unsigned sizes exist only for loads
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Address not naturally aligned for the access size
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: combinational byte-lane logic. Store side builds per-byte
// enables and lane-replicated write data; load side shifts the addressed
// byte/halfword down and sign- or zero-extends it.
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              st_size,
    input  logic [1:0]              st_lo,
    input  logic [DATA_WIDTH-1:0]   st_data,
    output logic [DATA_WIDTH/8-1:0] st_wen,
    output logic [DATA_WIDTH-1:0]   st_wdata,
    input  logic [2:0]              ld_funct3,
    input  logic [1:0]              ld_lo,
    input  logic [DATA_WIDTH-1:0]   ld_word,
    output logic [DATA_WIDTH-1:0]   ld_data
);

    logic [DATA_WIDTH-1:0] ld_shift_s;

    // Store lanes: enables follow the low address bits, data is replicated into every lane
    always_comb begin
        case (st_size)
            2'b00: begin
                st_wen   = 4'b0001 << st_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_wen   = 4'b0011 << st_lo;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_wen   = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load extract: bring the addressed lane to bit 0, then extend per size code
    always_comb begin
        ld_shift_s = ld_word >> {ld_lo, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_BU:   ld_data = {24'h000000, ld_shift_s[7:0]};
            F3_H:    ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_HU:   ld_data = {16'h0000, ld_shift_s[15:0]};
            default: ld_data = ld_shift_s;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit in front of a synchronous single-port memory.
// Stores write in the accept cycle and respond one cycle later; loads wait
// one cycle for memory data, then respond. Build option
// RV_LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are reported as errors
// instead of being silently forced aligned.
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    lsu_state_t            state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            f3_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;

    logic [ADDR_WIDTH-1:0]   eff_addr_s;
    logic                    req_ok_s;
    logic                    accept_s;
    logic [DATA_WIDTH/8-1:0] st_wen_s;
    logic [DATA_WIDTH-1:0]   st_wdata_s;
    logic [DATA_WIDTH-1:0]   ld_data_s;

    rv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_size   (req_funct3[1:0]),
        .st_lo     (eff_addr_s[1:0]),
        .st_data   (req_wdata),
        .st_wen    (st_wen_s),
        .st_wdata  (st_wdata_s),
        .ld_funct3 (f3_r),
        .ld_lo     (addr_r[1:0]),
        .ld_word   (mem_rdata),
        .ld_data   (ld_data_s)
    );

    // Effective address and legality of the incoming request
    always_comb begin
        eff_addr_s = req_addr;
`ifdef RV_LSU_MISALIGN_TRAP_EN
        if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            req_ok_s = 1'b0;
        end else begin
            req_ok_s = f3_legal(req_we, req_funct3);
        end
`else
        req_ok_s = f3_legal(req_we, req_funct3);
        case (req_funct3[1:0])
            2'b01:   eff_addr_s[0]   = 1'b0;
            2'b10:   eff_addr_s[1:0] = 2'b00;
            default: eff_addr_s      = req_addr;
        endcase
`endif
    end

    assign req_ready = (state_r == IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    assign mem_wdata = st_wdata_s;
    assign rsp_valid = (state_r == RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Memory port: live request address in IDLE, held address while an access is in flight
    always_comb begin
        mem_wen = '0;
        if (state_r == IDLE) begin
            mem_addr = eff_addr_s;
            if (accept_s && req_we && req_ok_s) begin
                mem_wen = st_wen_s;
            end else begin
                mem_wen = '0;
            end
        end else begin
            mem_addr = addr_r;
        end
    end

    // Access sequencing and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            f3_r        <= 3'b000;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r      <= eff_addr_s;
                        f3_r        <= req_funct3;
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= ~req_ok_s;
                        if (req_ok_s && !req_we) begin
                            state_r <= LD_DATA;
                        end else begin
                            state_r <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LD_DATA: begin
                    rsp_rdata_r <= ld_data_s;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
